// File: rtl/key_request_latch_pkg.sv
// Shared definitions for the key request front-end and the 8-to-3 priority encoder.
// Bit KEY_HI_PRIO of a request vector is the highest priority.
package key_request_latch_pkg;

    localparam int N_KEYS      = 8;
    localparam int KEY_HI_PRIO = N_KEYS - 1;

    typedef logic [N_KEYS-1:0] key_vec_t;

    // One-hot mask of the highest-priority set bit; zero when nothing is set.
    function automatic key_vec_t top_onehot(input key_vec_t v);
        key_vec_t r;
        r = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) begin
                r = key_vec_t'(1) << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter, debounced level and rise strobe.
// Level and strobe are normalised so that 1 always means pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_rise
);

    localparam logic             RELEASED_RAW = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;

    assign w_sync  = r_s2 ^ ACTIVE_LOW;
    assign o_level = r_level;
    assign o_rise  = r_rise;

    // Any return to the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= RELEASED_RAW;
            r_s2    <= RELEASED_RAW;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_key;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST_CNT) begin
                r_level <= w_sync;
                r_rise  <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_request_latch.sv
// Debounced keys become sticky request bits; ack retires the highest pending one,
// clr_all drops them all, and a fresh press always wins over either.
module key_request_latch
    import key_request_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              ack,
    input  logic              clr_all,
    output logic [N_KEYS-1:0] req,
    output logic              any_req,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse
);

    key_vec_t r_req;
    logic     r_anyReq;
    key_vec_t w_level;
    key_vec_t w_pulse;
    key_vec_t w_top;
    key_vec_t w_reqNext;

    for (genvar g = 0; g < N_KEYS; g++) begin : gen_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_key  (key_in[g]),
            .o_level(w_level[g]),
            .o_rise (w_pulse[g])
        );
    end

    // The ack target is taken from the current register, before this cycle's sets.
    always_comb begin
        w_top     = top_onehot(r_req);
        w_reqNext = r_req;
        if (clr_all) begin
            w_reqNext = '0;
        end else if (ack) begin
            w_reqNext = r_req & ~w_top;
        end
        w_reqNext = w_reqNext | w_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req    <= '0;
            r_anyReq <= 1'b0;
        end else begin
            r_req    <= w_reqNext;
            r_anyReq <= |w_reqNext;
        end
    end

    assign req         = r_req;
    assign any_req     = r_anyReq;
    assign key_level   = w_level;
    assign press_pulse = w_pulse;

endmodule

// File: tb/tb_key_request_latch.sv
// Bench for key_request_latch: hand-derived vector table, directed corner sequences
// and a long random run, all cross-checked against a sample-window reference model.
module tb_key_request_latch;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] keyIn = 8'hFF;
    logic       ack = 1'b0;
    logic       clrAll = 1'b0;
    logic [7:0] req;
    logic       anyReq;
    logic [7:0] keyLevel;
    logic [7:0] pressPulse;

    int checks = 0;
    int passed = 0;

    // Reference model state: raw samples still in the synchroniser, the last D
    // samples that reached the debouncer, and the expected outputs.
    logic [7:0] pipeQ[$];
    logic [7:0] winQ[$];
    logic [7:0] mLevel;
    logic [7:0] mPulse;
    logic [7:0] mReq;
    logic       mAny;

    typedef struct {
        logic [7:0] keyIn;
        logic [7:0] expLevel;
        logic [7:0] expPulse;
        logic [7:0] expReq;
        logic       expAny;
    } vec_t;

    vec_t vecs[17];

    key_request_latch #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (keyIn),
        .ack        (ack),
        .clr_all    (clrAll),
        .req        (req),
        .any_req    (anyReq),
        .key_level  (keyLevel),
        .press_pulse(pressPulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic modelReset();
        pipeQ.delete();
        winQ.delete();
        pipeQ.push_back(8'h00);
        pipeQ.push_back(8'h00);
        for (int i = 0; i < D; i++) winQ.push_back(8'h00);
        mLevel = 8'h00;
        mPulse = 8'h00;
        mReq   = 8'h00;
        mAny   = 1'b0;
    endtask

    // A key's level flips once its last D synchronised samples all disagree with it.
    task automatic modelEdge(input logic [7:0] k, input logic a, input logic c, input logic r);
        logic [7:0] used;
        logic [7:0] nextReq;
        logic [7:0] nextPulse;
        logic       allDiff;
        if (r) begin
            modelReset();
            return;
        end
        used = pipeQ.pop_front();
        pipeQ.push_back(~k);
        void'(winQ.pop_front());
        winQ.push_back(used);

        nextReq = mReq;
        if (c) begin
            nextReq = 8'h00;
        end else if (a) begin
            for (int i = 7; i >= 0; i--) begin
                if (mReq[i]) begin
                    nextReq[i] = 1'b0;
                    break;
                end
            end
        end
        nextReq = nextReq | mPulse;

        nextPulse = 8'h00;
        for (int i = 0; i < 8; i++) begin
            allDiff = 1'b1;
            foreach (winQ[j]) if (winQ[j][i] == mLevel[i]) allDiff = 1'b0;
            if (allDiff) begin
                mLevel[i] = ~mLevel[i];
                nextPulse[i] = mLevel[i];
            end
        end
        mPulse = nextPulse;
        mReq   = nextReq;
        mAny   = |nextReq;
    endtask

    task automatic applyStimulus(input logic [7:0] k, input logic a, input logic c, input logic r);
        keyIn  = k;
        ack    = a;
        clrAll = c;
        rst    = r;
        @(posedge clk);
        modelEdge(k, a, c, r);
        #1;
        checkOutput("model key_level", keyLevel, mLevel);
        checkOutput("model press_pulse", pressPulse, mPulse);
        checkOutput("model req", req, mReq);
        checkOutput("model any_req", {7'd0, anyReq}, {7'd0, mAny});
    endtask

    task automatic idle(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(k, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] heldKeys;

        // Key 3 held for 10 cycles then released: pulse on edge 6, req from edge 7.
        for (int i = 0; i < 17; i++) begin
            vecs[i].keyIn    = (i < 10) ? 8'hF7 : 8'hFF;
            vecs[i].expLevel = (i >= 5 && i < 15) ? 8'h08 : 8'h00;
            vecs[i].expPulse = (i == 5) ? 8'h08 : 8'h00;
            vecs[i].expReq   = (i >= 6) ? 8'h08 : 8'h00;
            vecs[i].expAny   = (i >= 6);
        end

        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        checkOutput("reset req", req, 8'h00);
        checkOutput("reset any_req", {7'd0, anyReq}, 8'h00);
        checkOutput("reset key_level", keyLevel, 8'h00);
        checkOutput("reset press_pulse", pressPulse, 8'h00);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].keyIn, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d key_level", i), keyLevel, vecs[i].expLevel);
            checkOutput($sformatf("vec%0d press_pulse", i), pressPulse, vecs[i].expPulse);
            checkOutput($sformatf("vec%0d req", i), req, vecs[i].expReq);
            checkOutput($sformatf("vec%0d any_req", i), {7'd0, anyReq}, {7'd0, vecs[i].expAny});
        end

        // Three-cycle glitch on key 5 never debounces.
        idle(8'hDF, 3);
        idle(8'hFF, 8);
        checkOutput("glitch key_level", keyLevel, 8'h00);
        checkOutput("glitch req", req, 8'h08);

        // Keys 1 and 6, then two acks retire 6 first, then 1.
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        idle(8'hBD, 10);
        checkOutput("keys16 req", req, 8'h42);
        applyStimulus(8'hBD, 1'b1, 1'b0, 1'b0);
        checkOutput("ack1 req", req, 8'h02);
        applyStimulus(8'hBD, 1'b1, 1'b0, 1'b0);
        checkOutput("ack2 req", req, 8'h00);
        checkOutput("ack2 any_req", {7'd0, anyReq}, 8'h00);
        idle(8'hFF, 8);

        // Ack lands on the cycle key 7 re-debounces: the set wins.
        idle(8'h7F, 10);
        idle(8'hFF, 8);
        idle(8'h7F, 6);
        checkOutput("key7 repulse", pressPulse, 8'h80);
        applyStimulus(8'h7F, 1'b1, 1'b0, 1'b0);
        checkOutput("set beats ack req", req, 8'h80);
        idle(8'hFF, 8);

        // clr_all together with a new press keeps only the new bit.
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        idle(8'hFA, 10);
        checkOutput("keys02 req", req, 8'h05);
        idle(8'hFF, 8);
        idle(8'hEF, 6);
        checkOutput("key4 pulse", pressPulse, 8'h10);
        applyStimulus(8'hEF, 1'b0, 1'b1, 1'b0);
        checkOutput("clr with set req", req, 8'h10);
        applyStimulus(8'hEF, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hEF, 1'b1, 1'b0, 1'b0);
        checkOutput("ack empty req", req, 8'h00);
        checkOutput("ack empty any_req", {7'd0, anyReq}, 8'h00);
        idle(8'hFF, 8);

        // Reset in the middle of key 2's debounce leaves nothing behind.
        idle(8'hFB, 4);
        applyStimulus(8'hFB, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst key_level", keyLevel, 8'h00);
        checkOutput("midrst press_pulse", pressPulse, 8'h00);
        checkOutput("midrst req", req, 8'h00);
        idle(8'hFF, 10);
        checkOutput("after midrst req", req, 8'h00);

        heldKeys = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7, 0) == 0) heldKeys = heldKeys ^ (8'h01 << $urandom_range(7, 0));
            applyStimulus(heldKeys,
                          ($urandom_range(9, 0) == 0),
                          ($urandom_range(39, 0) == 0),
                          ($urandom_range(499, 0) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
